// File: rtl/icache_responder.sv
// icache_responder: direct-mapped instruction line store with one-outstanding BUS_LOAD miss handling (optional ICACHE_FILL_BYPASS_EN)
module icache_responder #(
  parameter int NUM_PORTS = 4,
  parameter int NUM_LINES = 32,
  parameter int XLEN = 32
) (
  input  logic                            clock,
  input  logic                            reset_n,
  input  logic [NUM_PORTS-1:0][XLEN-1:0]  proc2Imem_addrs,
  output logic [NUM_PORTS-1:0][63:0]      Imem2proc_datas,
  output logic [NUM_PORTS-1:0]            hit,
  output logic [1:0]                      proc2Mem_command,
  output logic [XLEN-1:0]                 proc2Mem_addr,
  input  logic [3:0]                      Mem2proc_response,
  input  logic [63:0]                     Mem2proc_data,
  input  logic [3:0]                      Mem2proc_tag
);
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
  localparam int IDXW = $clog2(NUM_LINES);
  localparam int TAGW = XLEN - 3 - IDXW;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_n;
  logic [NUM_LINES-1:0] valid;
  logic [TAGW-1:0] tags [NUM_LINES];
  logic [63:0] lines [NUM_LINES];
  logic [XLEN-1:0] miss_addr, miss_addr_n, victim_addr;
  logic [3:0] pend_tag, pend_tag_n;
  logic [IDXW-1:0] fill_idx;
  logic fill, miss, unused_low;
  assign fill = state == WAIT && pend_tag != 4'd0 && Mem2proc_tag == pend_tag;
  assign fill_idx = miss_addr[3 +: IDXW];
  // per-port lookup; the filling line is forwarded straight from the bus when bypass is built in
  always_comb begin
    hit = '0;
    Imem2proc_datas = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      hit[i] = valid[proc2Imem_addrs[i][3 +: IDXW]] && tags[proc2Imem_addrs[i][3 +: IDXW]] == proc2Imem_addrs[i][XLEN-1:3+IDXW];
      Imem2proc_datas[i] = hit[i] ? lines[proc2Imem_addrs[i][3 +: IDXW]] : 64'd0;
`ifdef ICACHE_FILL_BYPASS_EN
      if (fill && proc2Imem_addrs[i][XLEN-1:3] == miss_addr[XLEN-1:3]) begin
        hit[i] = 1'b1;
        Imem2proc_datas[i] = Mem2proc_data;
      end
`endif
    end
  end
  // victim is the highest-numbered missing port, i.e. the one closest to the queue head
  always_comb begin
    miss = 1'b0;
    victim_addr = '0;
    unused_low = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      unused_low = unused_low ^ (^proc2Imem_addrs[i][2:0]);
      if (!hit[i]) begin
        miss = 1'b1;
        victim_addr = {proc2Imem_addrs[i][XLEN-1:3], 3'b000};
      end
    end
  end
  // miss FSM: latch victim, request until accepted, then wait for the matching tag
  always_comb begin
    state_n = state;
    miss_addr_n = miss_addr;
    pend_tag_n = pend_tag;
    proc2Mem_command = BUS_NONE;
    proc2Mem_addr = '0;
    case (state)
      IDLE: if (miss) begin
        state_n = ISSUE;
        miss_addr_n = victim_addr;
      end
      ISSUE: begin
        proc2Mem_command = BUS_LOAD;
        proc2Mem_addr = miss_addr;
        if (Mem2proc_response != 4'd0) begin
          pend_tag_n = Mem2proc_response;
          state_n = WAIT;
        end
      end
      WAIT: if (fill) begin
        state_n = IDLE;
`ifdef ICACHE_FILL_BYPASS_EN
        if (miss) begin
          state_n = ISSUE;
          miss_addr_n = victim_addr;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end
  // control state and valid bits; reset also drops any response still in flight
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      miss_addr <= '0;
      pend_tag <= '0;
      valid <= '0;
    end else begin
      state <= state_n;
      miss_addr <= miss_addr_n;
      pend_tag <= pend_tag_n;
      if (fill) valid[fill_idx] <= 1'b1;
    end
  end
  // line payload needs no reset since valid gates every use of it
  always_ff @(posedge clock) begin
    if (fill) begin
      tags[fill_idx] <= miss_addr[XLEN-1:3+IDXW];
      lines[fill_idx] <= Mem2proc_data;
    end
  end
endmodule

// File: tb/tb_icache_responder.sv
// tb_icache_responder: scenario tasks plus randomized rounds against a line-address cache model
module tb_icache_responder;
  localparam int NP = 4;
  localparam int NL = 32;
  localparam logic [1:0] BUS_NONE = 2'd0;
  localparam logic [1:0] BUS_LOAD = 2'd1;
`ifdef ICACHE_FILL_BYPASS_EN
  localparam logic BYP = 1'b1;
`else
  localparam logic BYP = 1'b0;
`endif
  typedef logic [NP-1:0][63:0] datas_t;
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  logic [NP-1:0][31:0] addrs;
  datas_t datas;
  logic [NP-1:0] hit;
  logic [1:0] cmd;
  logic [31:0] maddr;
  logic [3:0] resp = '0;
  logic [3:0] mtag = '0;
  logic [63:0] mdata = '0;
  int checks = 0;
  int errors = 0;
  bit mv [NL];
  logic [28:0] mline [NL];
  logic [63:0] mdat [NL];

  always #5 clock = ~clock;

  icache_responder dut (
    .clock(clock), .reset_n(reset_n), .proc2Imem_addrs(addrs), .Imem2proc_datas(datas), .hit(hit),
    .proc2Mem_command(cmd), .proc2Mem_addr(maddr), .Mem2proc_response(resp), .Mem2proc_data(mdata), .Mem2proc_tag(mtag)
  );

  function automatic int slot(logic [31:0] a);
    return int'((a >> 3) % NL);
  endfunction
  function automatic logic m_hit(logic [31:0] a);
    return mv[slot(a)] && mline[slot(a)] == a[31:3];
  endfunction
  function automatic logic [NP-1:0] exp_hits();
    logic [NP-1:0] h;
    for (int i = 0; i < NP; i++) h[i] = m_hit(addrs[i]);
    return h;
  endfunction
  function automatic datas_t exp_datas();
    datas_t d;
    for (int i = 0; i < NP; i++) d[i] = m_hit(addrs[i]) ? mdat[slot(addrs[i])] : 64'd0;
    return d;
  endfunction
  function automatic int m_victim();
    for (int i = NP - 1; i >= 0; i--) if (!m_hit(addrs[i])) return i;
    return -1;
  endfunction
  task automatic m_install(input logic [31:0] a, input logic [63:0] d);
    mv[slot(a)] = 1'b1;
    mline[slot(a)] = a[31:3];
    mdat[slot(a)] = d;
  endtask
  task automatic m_clear();
    for (int i = 0; i < NL; i++) mv[i] = 1'b0;
  endtask
  task automatic tick();
    @(posedge clock);
    #1;
  endtask
  task automatic set_cold(input logic [31:0] base);
    for (int i = 0; i < NP; i++) addrs[i] = base + 32'h18 - 32'(8 * i);
  endtask
  task automatic do_reset();
    reset_n = 1'b0;
    resp = '0;
    mtag = '0;
    mdata = '0;
    m_clear();
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask
  task automatic wait_issue(output logic [31:0] a, output bit to);
    to = 1'b1;
    a = '0;
    for (int k = 0; k < 20; k++) begin
      if (cmd === BUS_LOAD) begin
        a = maddr;
        to = 1'b0;
        break;
      end
      tick();
    end
  endtask
  task automatic serve(input logic [3:0] t, input logic [63:0] d, output logic [31:0] a, output bit to);
    wait_issue(a, to);
    if (!to) begin
      resp = t;
      tick();
      resp = '0;
      mtag = t;
      mdata = d;
      tick();
      mtag = '0;
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    set_cold(32'h100);
    m_clear();
    #3;
    checks++; if (hit !== '0) begin errors++; $display("FAIL reset_hit got=%b exp=%b", hit, 4'b0); end
    checks++; if (datas !== '0) begin errors++; $display("FAIL reset_data got=%h exp=0", datas); end
    checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL reset_cmd got=%0d exp=%0d", cmd, BUS_NONE); end
    checks++; if (maddr !== 32'h0) begin errors++; $display("FAIL reset_addr got=%h exp=0", maddr); end
    tick();
    checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL reset_held_cmd got=%0d exp=%0d", cmd, BUS_NONE); end
  endtask

  task automatic test_cold_miss();
    logic [63:0] d = 64'hDEADBEEF_00000013;
    set_cold(32'h100);
    do_reset();
    checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL cold_idle_cmd got=%0d exp=%0d", cmd, BUS_NONE); end
    tick();
    checks++; if ({cmd, maddr} !== {BUS_LOAD, 32'h100}) begin errors++; $display("FAIL cold_issue got=%0d/%h exp=%0d/100", cmd, maddr, BUS_LOAD); end
    resp = 4'd3;
    tick();
    resp = '0;
    checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL cold_wait_cmd got=%0d exp=%0d", cmd, BUS_NONE); end
    mtag = 4'd3;
    mdata = d;
    #1;
    checks++; if (hit[3] !== BYP) begin errors++; $display("FAIL cold_fill_cycle_hit got=%b exp=%b", hit[3], BYP); end
    tick();
    mtag = '0;
    m_install(32'h100, d);
    checks++; if (hit[3] !== 1'b1) begin errors++; $display("FAIL cold_hit got=%b exp=1", hit[3]); end
    checks++; if (datas[3] !== d) begin errors++; $display("FAIL cold_data got=%h exp=%h", datas[3], d); end
  endtask

  task automatic test_retry();
    logic [63:0] d = 64'h01234567_89ABCDEF;
    set_cold(32'h100);
    do_reset();
    tick();
    for (int k = 0; k < 4; k++) begin
      if (k == 3) resp = 4'd5;
      #1;
      checks++; if ({cmd, maddr} !== {BUS_LOAD, 32'h100}) begin errors++; $display("FAIL retry_hold%0d got=%0d/%h exp=%0d/100", k, cmd, maddr, BUS_LOAD); end
      tick();
    end
    resp = '0;
    mtag = 4'd2;
    mdata = 64'h1111;
    tick();
    mtag = '0;
    checks++; if (hit[3] !== 1'b0) begin errors++; $display("FAIL retry_wrong_tag_hit got=%b exp=0", hit[3]); end
    checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL retry_wait_cmd got=%0d exp=%0d", cmd, BUS_NONE); end
    mtag = 4'd5;
    mdata = d;
    tick();
    mtag = '0;
    m_install(32'h100, d);
    checks++; if ({hit[3], datas[3]} !== {1'b1, d}) begin errors++; $display("FAIL retry_fill got=%b/%h exp=1/%h", hit[3], datas[3], d); end
  endtask

  task automatic test_conflict();
    logic [31:0] a;
    bit to;
    for (int i = 0; i < NP; i++) addrs[i] = 32'h000;
    do_reset();
    serve(4'd1, 64'hA0A0, a, to);
    m_install(32'h000, 64'hA0A0);
    checks++; if (to || a !== 32'h000) begin errors++; $display("FAIL conflict_req0 got=%h to=%0d exp=0", a, to); end
    checks++; if (hit !== 4'b1111) begin errors++; $display("FAIL conflict_hit0 got=%b exp=1111", hit); end
    for (int i = 0; i < NP; i++) addrs[i] = 32'h100;
    #1;
    checks++; if (hit !== '0) begin errors++; $display("FAIL conflict_alias got=%b exp=0000", hit); end
    serve(4'd2, 64'hB1B1, a, to);
    m_install(32'h100, 64'hB1B1);
    checks++; if (to || a !== 32'h100) begin errors++; $display("FAIL conflict_req1 got=%h to=%0d exp=100", a, to); end
    addrs[2] = 32'h000;
    #1;
    checks++; if (hit !== exp_hits() || hit[2] !== 1'b0) begin errors++; $display("FAIL conflict_evict got=%b exp=%b", hit, exp_hits()); end
    checks++; if (datas !== exp_datas()) begin errors++; $display("FAIL conflict_data got=%h exp=%h", datas, exp_datas()); end
  endtask

  task automatic test_redirect();
    logic [31:0] a;
    bit to;
    set_cold(32'h100);
    do_reset();
    tick();
    resp = 4'd7;
    tick();
    resp = '0;
    set_cold(32'h400);
    tick();
    tick();
    checks++; if (cmd !== BUS_NONE) begin errors++; $display("FAIL redirect_no_new_req got=%0d exp=%0d", cmd, BUS_NONE); end
    mtag = 4'd7;
    mdata = 64'hC0FFEE;
    tick();
    mtag = '0;
    m_install(32'h100, 64'hC0FFEE);
    addrs[3] = 32'h100;
    #1;
    checks++; if ({hit[3], datas[3]} !== {1'b1, 64'hC0FFEE}) begin errors++; $display("FAIL redirect_install got=%b/%h exp=1/c0ffee", hit[3], datas[3]); end
    addrs[3] = 32'h400;
    #1;
    wait_issue(a, to);
    checks++; if (to || a !== 32'h400) begin errors++; $display("FAIL redirect_next_req got=%h to=%0d exp=400", a, to); end
  endtask

  task automatic test_async_reset();
    logic [31:0] a;
    bit to;
    set_cold(32'h100);
    do_reset();
    serve(4'd3, 64'h5555, a, to);
    m_install(32'h100, 64'h5555);
    wait_issue(a, to);
    checks++; if (to || a !== 32'h108) begin errors++; $display("FAIL async_second_req got=%h to=%0d exp=108", a, to); end
    resp = 4'd9;
    tick();
    resp = '0;
    checks++; if (hit[3] !== m_hit(addrs[3])) begin errors++; $display("FAIL async_pre_hit got=%b exp=%b", hit[3], m_hit(addrs[3])); end
    #2;
    reset_n = 1'b0;
    m_clear();
    #1;
    checks++; if (hit !== '0 || datas !== '0) begin errors++; $display("FAIL async_outputs got=%b/%h exp=0", hit, datas); end
    checks++; if ({cmd, maddr} !== {BUS_NONE, 32'h0}) begin errors++; $display("FAIL async_bus got=%0d/%h exp=0/0", cmd, maddr); end
    mtag = 4'd9;
    mdata = 64'h9999;
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    tick();
    mtag = '0;
    checks++; if (hit !== '0) begin errors++; $display("FAIL async_late_tag got=%b exp=0000", hit); end
    checks++; if ({cmd, maddr} !== {BUS_LOAD, 32'h100}) begin errors++; $display("FAIL async_restart got=%0d/%h exp=%0d/100", cmd, maddr, BUS_LOAD); end
  endtask

  task automatic test_random();
    logic [31:0] a, ea;
    logic [3:0] t;
    logic [63:0] d;
    int ln [NP];
    int v, n;
    bit to;
    for (int i = 0; i < NP; i++) addrs[i] = '0;
    do_reset();
    for (int r = 0; r < 30; r++) begin
      for (int i = 0; i < NP; i++) begin
        ln[i] = int'($urandom_range(0, 255));
        for (int j = 0; j < i; j++) if (ln[j] % NL == ln[i] % NL) ln[i] = ln[j];
        addrs[i] = 32'(ln[i] * 8) | 32'($urandom_range(0, 7));
      end
      #1;
      checks++; if (hit !== exp_hits() || datas !== exp_datas()) begin errors++; $display("FAIL rnd_lookup r%0d got=%b exp=%b", r, hit, exp_hits()); end
      for (int g = 0; g < 6 && m_victim() >= 0; g++) begin
        v = m_victim();
        ea = {addrs[v][31:3], 3'b000};
        t = 4'($urandom_range(1, 15));
        n = int'($urandom_range(0, 2));
        d = {$urandom, $urandom};
        wait_issue(a, to);
        checks++; if (to || a !== ea) begin errors++; $display("FAIL rnd_req r%0d got=%h to=%0d exp=%h", r, a, to, ea); end
        if (to) break;
        for (int k = 0; k < n; k++) begin
          tick();
          checks++; if ({cmd, maddr} !== {BUS_LOAD, ea}) begin errors++; $display("FAIL rnd_retry r%0d got=%0d/%h exp=%0d/%h", r, cmd, maddr, BUS_LOAD, ea); end
        end
        resp = t;
        tick();
        resp = '0;
        mtag = t % 4'd15 + 4'd1;
        mdata = ~d;
        tick();
        checks++; if (cmd !== BUS_NONE || hit !== exp_hits()) begin errors++; $display("FAIL rnd_wrong_tag r%0d got=%0d/%b exp=%0d/%b", r, cmd, hit, BUS_NONE, exp_hits()); end
        mtag = t;
        mdata = d;
        tick();
        mtag = '0;
        m_install(ea, d);
        checks++; if (hit !== exp_hits() || datas !== exp_datas()) begin errors++; $display("FAIL rnd_fill r%0d got=%b exp=%b", r, hit, exp_hits()); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_retry();
    test_conflict();
    test_redirect();
    test_async_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog expired after %0d checks", checks);
    $fatal(1);
  end
endmodule
